// File: rtl/serv_ram32_responder_pkg.sv
// Shared types and constants for the SERV <-> RAM32 bus responder.
// Holds the FSM state and grant encodings used by the parent and the host-port sub-module.
package serv_ram32_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IBUS = 1'b0,
    GNT_DBUS = 1'b1
  } gnt_e;

endpackage

// File: rtl/serv_ram32_host_port.sv
// Byte-wide host access path into RAM32.
// Combinational lane, write-enable and write-data generation, plus a registered read-lane mux.
module serv_ram32_host_port
  import serv_ram32_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned HOST_AW = ADDR_W + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                host_mode_i,
  input  logic                host_we_i,
  input  logic [HOST_AW-1:0]  host_addr_i,
  input  logic [BYTE_W-1:0]   host_wdata_i,
  input  logic [DATA_W-1:0]   ram_do_i,
  output logic [ADDR_W-1:0]   ram_a_o,
  output logic [SEL_W-1:0]    ram_we_o,
  output logic [DATA_W-1:0]   ram_di_o,
  output logic [BYTE_W-1:0]   host_rdata_o
);

  logic [1:0] lane;
  logic [1:0] lane_d;
  logic [1:0] lane_q;

  assign lane     = host_addr_i[1:0];
  assign ram_a_o  = ADDR_W'(host_addr_i[HOST_AW-1:2]);
  assign ram_we_o = host_we_i ? (SEL_W'(1) << lane) : '0;
  assign ram_di_o = DATA_W'(host_wdata_i) << {lane, 3'b000};

  // Lane is parked at 0 outside host mode so a stale lane never selects the read byte.
  assign lane_d = host_mode_i ? lane : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign host_rdata_o = ram_do_i[{lane_q, 3'b000} +: BYTE_W];

endmodule

// File: rtl/serv_ram32_responder.sv
// Arbitrates SERV ibus/dbus onto the single RAM32 port with two-cycle acks,
// and hands the RAM to a byte-wide host port while the CPU is halted.
module serv_ram32_responder
  import serv_ram32_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned HOST_AW = ADDR_W + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_halt,
  input  logic                i_ibus_cyc,
  input  logic [31:0]         i_ibus_adr,
  output logic [DATA_W-1:0]   o_ibus_rdt,
  output logic                o_ibus_ack,
  input  logic                i_dbus_cyc,
  input  logic [31:0]         i_dbus_adr,
  input  logic                i_dbus_we,
  input  logic [DATA_W-1:0]   i_dbus_wdt,
  input  logic [SEL_W-1:0]    i_dbus_sel,
  output logic [DATA_W-1:0]   o_dbus_rdt,
  output logic                o_dbus_ack,
  input  logic                host_we,
  input  logic [HOST_AW-1:0]  host_addr,
  input  logic [BYTE_W-1:0]   host_wdata,
  output logic [BYTE_W-1:0]   host_rdata,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_a,
  output logic [SEL_W-1:0]    ram_we,
  output logic [DATA_W-1:0]   ram_di,
  input  logic [DATA_W-1:0]   ram_do
);

  state_e              state_q, state_d;
  gnt_e                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdt_q, wdt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                ibus_ack_q, ibus_ack_d;
  logic                dbus_ack_q, dbus_ack_d;
  logic                ibus_cool_q, ibus_cool_d;
  logic                dbus_cool_q, dbus_cool_d;

  logic                host_mode;
  logic [ADDR_W-1:0]   hp_a;
  logic [SEL_W-1:0]    hp_we;
  logic [DATA_W-1:0]   hp_di;
  logic                unused_adr;

  assign host_mode = (state_q == IDLE) && cpu_halt;

  // Upper address bits alias the RAM; byte offset is irrelevant for word accesses.
  assign unused_adr = ^{i_ibus_adr[31:ADDR_W+2], i_ibus_adr[1:0],
                        i_dbus_adr[31:ADDR_W+2], i_dbus_adr[1:0]};

  serv_ram32_host_port #(
    .ADDR_W  (ADDR_W),
    .HOST_AW (HOST_AW)
  ) u_host_port (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_mode_i  (host_mode),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .ram_do_i     (ram_do),
    .ram_a_o      (hp_a),
    .ram_we_o     (hp_we),
    .ram_di_o     (hp_di),
    .host_rdata_o (host_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IBUS;
      idx_q       <= '0;
      we_q        <= 1'b0;
      wdt_q       <= '0;
      sel_q       <= '0;
      ibus_ack_q  <= 1'b0;
      dbus_ack_q  <= 1'b0;
      ibus_cool_q <= 1'b0;
      dbus_cool_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      wdt_q       <= wdt_d;
      sel_q       <= sel_d;
      ibus_ack_q  <= ibus_ack_d;
      dbus_ack_q  <= dbus_ack_d;
      ibus_cool_q <= ibus_cool_d;
      dbus_cool_q <= dbus_cool_d;
    end
  end

  // Next-state: dbus has priority; a port just acked sits out one IDLE cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    we_d        = we_q;
    wdt_d       = wdt_q;
    sel_d       = sel_q;
    ibus_ack_d  = 1'b0;
    dbus_ack_d  = 1'b0;
    ibus_cool_d = 1'b0;
    dbus_cool_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!cpu_halt) begin
          if (i_dbus_cyc && !dbus_cool_q) begin
            state_d = ACCESS;
            gnt_d   = GNT_DBUS;
            idx_d   = i_dbus_adr[ADDR_W+1:2];
            we_d    = i_dbus_we;
            wdt_d   = i_dbus_wdt;
            sel_d   = i_dbus_sel;
          end else if (i_ibus_cyc && !ibus_cool_q) begin
            state_d = ACCESS;
            gnt_d   = GNT_IBUS;
            idx_d   = i_ibus_adr[ADDR_W+1:2];
            we_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        state_d    = ACK;
        ibus_ack_d = (gnt_q == GNT_IBUS);
        dbus_ack_d = (gnt_q == GNT_DBUS);
      end
      ACK: begin
        state_d     = IDLE;
        ibus_cool_d = (gnt_q == GNT_IBUS);
        dbus_cool_d = (gnt_q == GNT_DBUS);
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port mux: host owns the port in halted IDLE, the FSM owns it in ACCESS.
  always_comb begin
    ram_en = 1'b0;
    ram_a  = idx_q;
    ram_we = '0;
    ram_di = '0;
    if (host_mode) begin
      ram_en = 1'b1;
      ram_a  = hp_a;
      ram_we = hp_we;
      ram_di = hp_di;
    end else if (state_q == ACCESS) begin
      ram_en = 1'b1;
      if (we_q) begin
        ram_we = sel_q;
        ram_di = wdt_q;
      end
    end
    if (!rst_n) begin
      ram_en = 1'b0;
      ram_we = '0;
    end
  end

  assign o_ibus_ack = ibus_ack_q;
  assign o_dbus_ack = dbus_ack_q;
  assign o_ibus_rdt = ram_do;
  assign o_dbus_rdt = ram_do;

endmodule

// File: tb/tb_serv_ram32_responder.sv
// Directed bench for serv_ram32_responder with a behavioural RAM32 model.
module tb_serv_ram32_responder;

  logic        clk;
  logic        rst_n;
  logic        cpu_halt;
  logic        i_ibus_cyc;
  logic [31:0] i_ibus_adr;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        i_dbus_cyc;
  logic [31:0] i_dbus_adr;
  logic        i_dbus_we;
  logic [31:0] i_dbus_wdt;
  logic [3:0]  i_dbus_sel;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        ram_en;
  logic [4:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  logic [31:0] mem [32];
  int          n_checks;
  int          n_errors;

  serv_ram32_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_halt   (cpu_halt),
    .i_ibus_cyc (i_ibus_cyc),
    .i_ibus_adr (i_ibus_adr),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_cyc (i_dbus_cyc),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_wdt (i_dbus_wdt),
    .i_dbus_sel (i_dbus_sel),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .ram_en     (ram_en),
    .ram_a      (ram_a),
    .ram_we     (ram_we),
    .ram_di     (ram_di),
    .ram_do     (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM32 model: synchronous read of the old word, byte write enables, Do held while EN=0.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic host_write(input logic [6:0] addr, input logic [7:0] data);
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    tick();
    host_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    cpu_halt   = 1'b0;
    i_ibus_cyc = 1'b1;
    i_ibus_adr = 32'h0000_000C;
    i_dbus_cyc = 1'b1;
    i_dbus_adr = 32'h0;
    i_dbus_we  = 1'b0;
    i_dbus_wdt = 32'h0;
    i_dbus_sel = 4'h0;
    host_we    = 1'b0;
    host_addr  = 7'h0;
    host_wdata = 8'h0;

    // Reset held with both requests active
    tick();
    for (int c = 0; c < 5; c++) begin
      sample();
      check("rst_ibus_ack", 32'(o_ibus_ack), 0);
      check("rst_dbus_ack", 32'(o_dbus_ack), 0);
      check("rst_ram_en", 32'(ram_en), 0);
      check("rst_ram_we", 32'(ram_we), 0);
      tick();
    end

    // First grant only after release
    rst_n      = 1'b1;
    i_dbus_cyc = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) i_ibus_cyc = 1'b0;
      sample();
      check("rel_ram_en", 32'(ram_en), 32'(c == 1));
      check("rel_ibus_ack", 32'(o_ibus_ack), 32'(c == 2));
      if (c == 1) check("rel_ram_a", 32'(ram_a), 3);
      tick();
    end

    // Host writes and read-back, including last word / lane 3
    cpu_halt   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 7'h05;
    host_wdata = 8'hA5;
    sample();
    check("host_en", 32'(ram_en), 1);
    check("host_a", 32'(ram_a), 1);
    check("host_we", 32'(ram_we), 32'h2);
    check("host_di", ram_di, 32'h0000_A500);
    tick();
    host_we = 1'b0;
    sample();
    check("host_rd_we", 32'(ram_we), 0);
    tick();
    sample();
    check("host_rdata1", 32'(host_rdata), 32'hA5);
    host_we    = 1'b1;
    host_addr  = 7'h7F;
    host_wdata = 8'h5A;
    sample();
    check("host_a31", 32'(ram_a), 31);
    check("host_we3", 32'(ram_we), 32'h8);
    check("host_di3", ram_di, 32'h5A00_0000);
    tick();
    host_we = 1'b0;
    tick();
    sample();
    check("host_rdata3", 32'(host_rdata), 32'h5A);

    // Preload word 3 = 0x00000013 through the host port
    host_write(7'd12, 8'h13);
    host_write(7'd13, 8'h00);
    host_write(7'd14, 8'h00);
    host_write(7'd15, 8'h00);
    cpu_halt = 1'b0;
    tick();

    // ibus read; cyc dropped one cycle late to exercise cooldown
    i_ibus_cyc = 1'b1;
    i_ibus_adr = 32'h0000_000C;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) i_ibus_cyc = 1'b0;
      sample();
      check("ird_ibus_ack", 32'(o_ibus_ack), 32'(c == 2));
      check("ird_dbus_ack", 32'(o_dbus_ack), 0);
      check("ird_ram_en", 32'(ram_en), 32'(c == 1));
      if (c == 1) check("ird_ram_a", 32'(ram_a), 3);
      if (c == 1) check("ird_ram_we", 32'(ram_we), 0);
      if (c == 2) check("ird_rdt", o_ibus_rdt, 32'h0000_0013);
      tick();
    end

    // Preload word 3 = 0x11223344, then dbus partial write
    cpu_halt = 1'b1;
    host_write(7'd12, 8'h44);
    host_write(7'd13, 8'h33);
    host_write(7'd14, 8'h22);
    host_write(7'd15, 8'h11);
    cpu_halt = 1'b0;
    tick();
    i_dbus_cyc = 1'b1;
    i_dbus_we  = 1'b1;
    i_dbus_adr = 32'h0000_000C;
    i_dbus_wdt = 32'hDEAD_BEEF;
    i_dbus_sel = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        i_dbus_cyc = 1'b0;
        i_dbus_we  = 1'b0;
      end
      sample();
      check("dwr_dbus_ack", 32'(o_dbus_ack), 32'(c == 2));
      check("dwr_ibus_ack", 32'(o_ibus_ack), 0);
      if (c == 1) begin
        check("dwr_ram_en", 32'(ram_en), 1);
        check("dwr_ram_a", 32'(ram_a), 3);
        check("dwr_ram_we", 32'(ram_we), 32'hC);
        check("dwr_ram_di", ram_di, 32'hDEAD_BEEF);
      end
      tick();
    end

    // dbus read-back of the merged word
    i_dbus_cyc = 1'b1;
    i_dbus_sel = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) i_dbus_cyc = 1'b0;
      sample();
      check("drd_dbus_ack", 32'(o_dbus_ack), 32'(c == 2));
      if (c == 1) check("drd_ram_we", 32'(ram_we), 0);
      if (c == 2) check("drd_rdt", o_dbus_rdt, 32'hDEAD_3344);
      tick();
    end

    // Contention; dbus address aliases word 3, ibus has nonzero byte offset
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        i_ibus_cyc = 1'b1;
        i_ibus_adr = 32'h0000_000F;
        i_dbus_cyc = 1'b1;
        i_dbus_adr = 32'hFFFF_FF8C;
      end
      if (c == 3) i_dbus_cyc = 1'b0;
      if (c == 6) i_ibus_cyc = 1'b0;
      sample();
      check("arb_dbus_ack", 32'(o_dbus_ack), 32'(c == 2));
      check("arb_ibus_ack", 32'(o_ibus_ack), 32'(c == 5));
      check("arb_excl", 32'(o_ibus_ack & o_dbus_ack), 0);
      if (c == 4) check("arb_ram_a", 32'(ram_a), 3);
      if (c == 2) check("arb_drdt", o_dbus_rdt, 32'hDEAD_3344);
      if (c == 5) check("arb_irdt", o_ibus_rdt, 32'hDEAD_3344);
      tick();
    end
    tick();

    // Reset asserted during ACCESS aborts the transaction
    i_ibus_cyc = 1'b1;
    i_ibus_adr = 32'h0000_000C;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) rst_n = 1'b0;
      if (c == 2) begin
        rst_n      = 1'b1;
        i_ibus_cyc = 1'b0;
      end
      sample();
      check("mrst_ibus_ack", 32'(o_ibus_ack), 0);
      if (c >= 1) check("mrst_ram_en", 32'(ram_en), 0);
      tick();
    end
    i_ibus_cyc = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) i_ibus_cyc = 1'b0;
      sample();
      check("rereq_ibus_ack", 32'(o_ibus_ack), 32'(c == 2));
      if (c == 2) check("rereq_rdt", o_ibus_rdt, 32'hDEAD_3344);
      tick();
    end
    tick();

    // Halt raised during ACCESS: current ack completes, pending ibus waits for release
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        i_dbus_cyc = 1'b1;
        i_dbus_we  = 1'b0;
        i_dbus_adr = 32'h0000_000C;
      end
      if (c == 1) begin
        cpu_halt   = 1'b1;
        i_ibus_cyc = 1'b1;
        i_ibus_adr = 32'h0000_000C;
      end
      if (c == 3) i_dbus_cyc = 1'b0;
      if (c == 7) cpu_halt = 1'b0;
      if (c == 10) i_ibus_cyc = 1'b0;
      sample();
      check("halt_dbus_ack", 32'(o_dbus_ack), 32'(c == 2));
      check("halt_ibus_ack", 32'(o_ibus_ack), 32'(c == 9));
      if (c == 1) check("halt_acc_a", 32'(ram_a), 3);
      if (c == 2) check("halt_drdt", o_dbus_rdt, 32'hDEAD_3344);
      if (c == 9) check("halt_irdt", o_ibus_rdt, 32'hDEAD_3344);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serv_ram32_responder.md
Name: serv_ram32_responder

Overview:
Bus responder between the SERV core's instruction bus (ibus) and data bus (dbus) and the single-port RAM32 macro (32 words x 32 bits, byte write enables, synchronous read).
- Arbitrates the two SERV initiator ports onto the one RAM port.
- Generates one-cycle ack pulses with correct read latency.
- Provides a byte-wide host port that loads and inspects RAM while the CPU is halted.
- Sits between serv_top and RAM32 in the top-level tile.

Parameters:
ADDR_W, 5, RAM word-address width (RAM depth = 2**ADDR_W words)
HOST_AW, 7, host byte-address width (= ADDR_W + 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cpu_halt  in  1  1 = host owns RAM; CPU requests are stalled
i_ibus_cyc  in  1  ibus request
i_ibus_adr  in  32  ibus byte address
o_ibus_rdt  out  32  ibus read data
o_ibus_ack  out  1  ibus ack pulse
i_dbus_cyc  in  1  dbus request
i_dbus_adr  in  32  dbus byte address
i_dbus_we  in  1  dbus write
i_dbus_wdt  in  32  dbus write data
i_dbus_sel  in  4  dbus byte lane select
o_dbus_rdt  out  32  dbus read data
o_dbus_ack  out  1  dbus ack pulse
host_we  in  1  host byte write strobe
host_addr  in  HOST_AW  host byte address
host_wdata  in  8  host write byte
host_rdata  out  8  host read byte
ram_en  out  1  RAM EN0
ram_a  out  ADDR_W  RAM A0
ram_we  out  4  RAM WE0
ram_di  out  32  RAM Di0
ram_do  in  32  RAM Do0

Behaviour:
- Reset: rst_n sampled at posedge clk.
  - Clears state to IDLE, o_ibus_ack=0, o_dbus_ack=0, grant register=ibus, cooldown flags=0, host lane register=0.
  - ram_en=0 and ram_we=0 while rst_n=0.
- Reset mid-transaction: aborts the transaction; no ack is issued; the requester must re-request.
- Address mapping: word index = adr[ADDR_W+1:2]. Upper bits are ignored, so the RAM aliases across the address space. adr[1:0] is ignored on both CPU buses.
- FSM states: IDLE, ACCESS, ACK.
  - IDLE, cpu_halt=0:
    - If i_dbus_cyc is set and dbus is not cooling down, grant dbus.
    - Else if i_ibus_cyc is set and ibus is not cooling down, grant ibus.
    - On a grant: register grant, word index, we (dbus only), wdt and sel; go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS (1 cycle):
    - ram_en=1, ram_a=registered index.
    - For a dbus write: ram_we=registered sel, ram_di=registered wdt. Otherwise ram_we=0.
    - Go to ACK.
  - ACK (1 cycle):
    - The granted port's ack=1; it is a flop set on the ACCESS->ACK edge.
    - ram_do is valid here. The RAM holds Do while EN=0.
    - Go to IDLE and set cooldown for the acked port.
- Latency: cyc sampled high in IDLE at cycle 0 -> ack high in cycle 2, exactly one cycle wide. Acks are mutually exclusive.
- Cooldown: the port just acked is not granted in the IDLE cycle immediately after ACK. This tolerates a requester that drops cyc one cycle late. Cooldown clears after one cycle.
- Write ack: the same timing as a read. rdt during a write ack is don't-care.
- Read data: o_ibus_rdt and o_dbus_rdt are combinational copies of ram_do. Their value is defined only while the corresponding ack=1.
- Simultaneous requests: dbus wins. ibus is served in the next grant opportunity after the dbus ACK, so ibus ack lands 3 cycles after the dbus ack.
- cpu_halt:
  - Sampled only in IDLE. Asserting it mid-transaction lets the current transaction complete and ack.
  - Once in IDLE with halt=1, no CPU grants are made; cyc remains pending.
- Host port (active when state=IDLE and cpu_halt=1):
  - lane = host_addr[1:0].
  - ram_en=1, ram_a=host_addr[HOST_AW-1:2].
  - ram_we = host_we ? (1<<lane) : 0.
  - ram_di = {24'b0,host_wdata} << (8*lane).
- host_rdata: ram_do[8*lane_q +: 8], where lane_q is the host lane registered each cycle. lane_q is forced to 0 when not in host mode. A host read therefore returns data one cycle after the address is presented.
- Outside host mode, ram_di is driven with the registered wdt, or 0.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/ACK), grant encoding (GNT_IBUS/GNT_DBUS), and constants DATA_W=32 and SEL_W=4.
- One natural sub-module: serv_ram32_host_port, the combinational lane/WE/Di generation plus the registered read-lane mux.
- The FSM and arbiter stay in the parent.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with cyc requests active -> both acks 0, ram_en=0, ram_we=0 throughout; the first grant happens only after release.
- Host write: cpu_halt=1, host_we=1, host_addr=7'h05, host_wdata=8'hA5 -> ram_a=1, ram_we=4'b0010, ram_di=32'h0000A500. Next, host_we=0 with the same address -> host_rdata=8'hA5 one cycle later.
- ibus read: word 3 preloaded with 32'h00000013; i_ibus_cyc=1, adr=32'h0000000C at cycle 0 -> ram_en=1 and ram_a=3 in cycle 1, o_ibus_ack=1 with rdt=32'h00000013 in cycle 2 only.
- dbus partial write: word 3=32'h11223344; dbus we=1, adr=32'h0C, wdt=32'hDEADBEEF, sel=4'b1100 -> ram_we=4'b1100 in cycle 1, o_dbus_ack in cycle 2. A following read of word 3 returns 32'hDEAD3344.
- Contention: ibus and dbus cyc rise together at cycle 0 -> o_dbus_ack at cycle 2, o_ibus_ack at cycle 5, never both high.
- Mid-operation events:
  - rst_n=0 during ACCESS -> no ack; FSM returns to IDLE.
  - cpu_halt=1 during ACCESS -> ack still issued in cycle 2; afterwards a pending ibus cyc gets no ack until cpu_halt=0.
